// File: rtl/echo_range_filter.sv
// Captures the ping driver's echo duration at the end of each listen window, keeps a
// power-of-two moving average and drives a hysteretic obstacle flag plus a no-echo flag.
module echo_range_filter #(
  parameter int               WIDTH         = 16,
  parameter int               AVG_LOG2      = 2,
  parameter logic [WIDTH-1:0] NEAR_THRESH   = 16'd1176,
  parameter logic [WIDTH-1:0] FAR_THRESH    = 16'd1470,
  parameter logic [WIDTH-1:0] NO_ECHO_VALUE = 16'hFFFF,
  parameter int               MISS_LIMIT    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             listening,
  input  logic [WIDTH-1:0] distance,
  output logic [WIDTH-1:0] avg_distance,
  output logic             avg_valid,
  output logic             obstacle,
  output logic             no_echo
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int SUM_W  = WIDTH + AVG_LOG2;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [AVG_LOG2:0] FILL_FULL = (AVG_LOG2 + 1)'(N);
  localparam logic [MISS_W-1:0] MISS_MAX  = MISS_W'(MISS_LIMIT);

  typedef enum logic [1:0] {WAIT_ARM, WAIT_END, UPDATE, COMPARE} state_t;

  state_t              state;
  logic                listening_d;
  logic [WIDTH-1:0]    sample_p0;
  logic [SUM_W-1:0]    sum_p1;
  logic [WIDTH-1:0]    sample_buf [N];
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [AVG_LOG2:0]   fill;
  logic [MISS_W-1:0]   miss;

  function automatic logic [WIDTH-1:0] trunc_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:AVG_LOG2];
  endfunction

  function automatic logic hyst(input logic [WIDTH-1:0] a, input logic prev);
    if (a <= NEAR_THRESH)     return 1'b1;
    else if (a >= FAR_THRESH) return 1'b0;
    else                      return prev;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= WAIT_ARM;
      listening_d  <= 1'b1;
      sample_p0    <= '0;
      sum_p1       <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      miss         <= '0;
      avg_distance <= '0;
      avg_valid    <= 1'b0;
      obstacle     <= 1'b0;
      no_echo      <= 1'b0;
      for (int i = 0; i < N; i++) sample_buf[i] <= '0;
    end else begin
      listening_d <= listening;
      avg_valid   <= 1'b0;
      case (state)
        WAIT_ARM: if (listening) state <= WAIT_END;
        // Stage p0: capture at the end of the listen window
        WAIT_END: begin
          if (!listening && listening_d) begin
            if (distance == '0) begin
              sample_p0 <= NO_ECHO_VALUE;
              if (miss != MISS_MAX) miss <= miss + 1'b1;
            end else begin
              sample_p0 <= distance;
              miss      <= '0;
            end
            state <= UPDATE;
          end
        end
        // Stage p1: running sum over the circular buffer
        UPDATE: begin
          sum_p1             <= sum_p1 - SUM_W'(sample_buf[wr_ptr]) + SUM_W'(sample_p0);
          sample_buf[wr_ptr] <= sample_p0;
          wr_ptr             <= wr_ptr + 1'b1;
          if (fill != FILL_FULL) fill <= fill + 1'b1;
          state <= COMPARE;
        end
        // Stage p2: publish average and flags once the buffer is full
        COMPARE: begin
          no_echo <= (miss == MISS_MAX);
          if (fill == FILL_FULL) begin
            avg_distance <= trunc_avg(sum_p1);
            avg_valid    <= 1'b1;
            obstacle     <= (miss == MISS_MAX) ? 1'b0 : hyst(trunc_avg(sum_p1), obstacle);
          end
          state <= WAIT_ARM;
        end
        default: state <= WAIT_ARM;
      endcase
    end
  end

endmodule

// File: tb/tb_echo_range_filter.sv
// Scoreboard bench for echo_range_filter: stimulus pushes expected updates, a monitor
// pops and compares them whenever avg_valid pulses.
module tb_echo_range_filter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        listening = 1'b1;
  logic [15:0] distance = '0;
  logic [15:0] avg_distance;
  logic        avg_valid, obstacle, no_echo;

  echo_range_filter dut (
    .clk(clk), .reset(reset), .listening(listening), .distance(distance),
    .avg_distance(avg_distance), .avg_valid(avg_valid), .obstacle(obstacle), .no_echo(no_echo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] avg;
    logic        obs;
    logic        ne;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every avg_valid pulse must match the oldest expectation, at the right cycle.
  always @(negedge clk) begin
    if (avg_valid) begin
      exp_t e;
      checks++;
      if (prev_valid) begin
        failures++;
        $display("FAIL pulse_width: avg_valid high two cycles in a row at cycle %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: avg=%0d obs=%0b ne=%0b at cycle %0d, none expected",
                 avg_distance, obstacle, no_echo, cyc);
      end else begin
        e = exp_q.pop_front();
        if (avg_distance !== e.avg || obstacle !== e.obs || no_echo !== e.ne || cyc != e.cyc) begin
          failures++;
          $display("FAIL update: got avg=%0d obs=%0b ne=%0b cyc=%0d, expected avg=%0d obs=%0b ne=%0b cyc=%0d",
                   avg_distance, obstacle, no_echo, cyc, e.avg, e.obs, e.ne, e.cyc);
        end
      end
    end
    prev_valid = avg_valid;
  end

  task automatic check_idle(input string name);
    checks++;
    if (avg_distance !== 16'd0 || avg_valid !== 1'b0 || obstacle !== 1'b0 || no_echo !== 1'b0) begin
      failures++;
      $display("FAIL %s: avg=%0d valid=%0b obs=%0b ne=%0b, expected all 0",
               name, avg_distance, avg_valid, obstacle, no_echo);
    end
  endtask

  // One listen window; optionally push the expected update it produces.
  task automatic window(input logic [15:0] d, input bit expect_upd,
                        input logic [15:0] ea, input logic eo, input logic en);
    exp_t e;
    @(negedge clk);
    listening = 1'b1;
    distance  = d;
    repeat (2) @(negedge clk);
    listening = 1'b0;
    if (expect_upd) begin
      e.avg = ea; e.obs = eo; e.ne = en; e.cyc = cyc + 3;
      exp_q.push_back(e);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    // Test 1: release reset with listening dropping at once; the fall in WAIT_ARM is ignored
    repeat (3) @(negedge clk);
    check_idle("reset_state");
    reset = 1'b1;
    listening = 1'b0;
    repeat (6) @(negedge clk);
    check_idle("after_release");

    // Test 2: four windows of 1000, update only after the 4th
    window(16'd1000, 0, 0, 0, 0);
    window(16'd1000, 0, 0, 0, 0);
    window(16'd1000, 0, 0, 0, 0);
    window(16'd1000, 1, 16'd1000, 1'b1, 1'b0);

    // Test 3: ramp to 1300 (hysteresis holds), then 2000 clears the flag
    window(16'd1300, 1, 16'd1075, 1'b1, 1'b0);
    window(16'd1300, 1, 16'd1150, 1'b1, 1'b0);
    window(16'd1300, 1, 16'd1225, 1'b1, 1'b0);
    window(16'd1300, 1, 16'd1300, 1'b1, 1'b0);
    window(16'd2000, 1, 16'd1475, 1'b0, 1'b0);

    // Test 4: three no-echo windows, then a real echo
    window(16'd0,   1, 16'd17533, 1'b0, 1'b0);
    window(16'd0,   1, 16'd33592, 1'b0, 1'b0);
    window(16'd0,   1, 16'd49651, 1'b0, 1'b1);
    window(16'd500, 1, 16'd49276, 1'b0, 1'b0);

    // Test 5: reset while in COMPARE aborts the pending update
    @(negedge clk);
    listening = 1'b1;
    distance  = 16'd1234;
    repeat (2) @(negedge clk);
    listening = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_idle("after_mid_reset");

    // Test 6: refill with near-full-scale samples, no sum overflow
    window(16'hFFFE, 0, 0, 0, 0);
    window(16'hFFFE, 0, 0, 0, 0);
    window(16'hFFFE, 0, 0, 0, 0);
    window(16'hFFFE, 1, 16'hFFFE, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_updates: %0d expected updates never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
